// File: rtl/stream_decimator.sv
// Multi-channel runtime-ratio decimator: bypass / keep-first / average / sum, valid-ready output.
// Latency 1 clk after the last sample of a block; in_ready drops while a word is held, and lost samples set a sticky overrun.
module stream_decimator #(
    parameter int DATA_WIDTH = 14,
    parameter int NUM_CH     = 2,
    parameter int MAX_LOG2   = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_in,
    input  logic [1:0]                                mode,
    input  logic [$clog2(MAX_LOG2+1)-1:0]             ratio_log2,
    input  logic                                      flush,
    input  logic                                      clr_ovr,
    input  logic                                      in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]              in_data,
    output logic                                      in_ready,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [NUM_CH*(DATA_WIDTH+MAX_LOG2)-1:0]   out_data,
    output logic                                      overrun
);
    localparam int OUT_WIDTH = DATA_WIDTH + MAX_LOG2;
    localparam int RW        = $clog2(MAX_LOG2 + 1);
    localparam int CW        = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_FIRST  = 2'b01;
    localparam logic [1:0] MODE_AVG    = 2'b10;

    logic [CW-1:0]                        cnt_q, cnt_d;
    logic [1:0]                           mode_q, mode_d;
    logic [RW-1:0]                        log2_q, log2_d;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0]     acc_q, acc_d;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0]     out_data_q, out_data_d;
    logic                                 out_valid_q, out_valid_d;
    logic                                 overrun_q, overrun_d;

    logic [NUM_CH-1:0][OUT_WIDTH-1:0]     smp_ext;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0]     acc_nxt;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0]     result;
    logic [RW-1:0]                        ratio_clamp;
    logic [1:0]                           cur_mode;
    logic [RW-1:0]                        cur_log2;
    logic                                 start;
    logic                                 last;
    logic                                 accept;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;

    // At block start the incoming config applies to the sample being accepted on the same edge.
    assign accept      = in_valid && in_ready && !flush;
    assign start       = (cnt_q == '0);
    assign ratio_clamp = (ratio_log2 > RW'(MAX_LOG2)) ? RW'(MAX_LOG2) : ratio_log2;
    assign cur_mode    = start ? mode : mode_q;
    assign cur_log2    = start ? ((mode == MODE_BYPASS) ? '0 : ratio_clamp) : log2_q;
    assign last        = (cnt_q == CW'((32'd1 << cur_log2) - 32'd1));

    always_comb begin
        smp_ext = '0;
        acc_nxt = '0;
        result  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            smp_ext[c] = OUT_WIDTH'($signed(in_data[c*DATA_WIDTH +: DATA_WIDTH]));
            if (start)
                acc_nxt[c] = smp_ext[c];
            else if (cur_mode == MODE_FIRST)
                acc_nxt[c] = acc_q[c];
            else
                acc_nxt[c] = acc_q[c] + smp_ext[c];
            if (cur_mode == MODE_AVG)
                result[c] = OUT_WIDTH'($signed(acc_nxt[c]) >>> cur_log2);
            else
                result[c] = acc_nxt[c];
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        log2_d      = log2_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        overrun_d   = (overrun_q && !clr_ovr) || (in_valid && !in_ready);
        if (flush) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            acc_d = acc_nxt;
            if (start) begin
                mode_d = mode;
                log2_d = cur_log2;
            end
            if (last) begin
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = result;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            cnt_q       <= '0;
            mode_q      <= MODE_BYPASS;
            log2_q      <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            log2_q      <= log2_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end
endmodule

// File: tb/tb_stream_decimator.sv
// Directed bench for stream_decimator: all modes, ratio clamp, backpressure/overrun, config change, flush, reset.
module tb_stream_decimator;
    localparam int DW = 14;
    localparam int NC = 2;
    localparam int ML = 4;
    localparam int OW = DW + ML;

    logic                  clk;
    logic                  rst_in;
    logic [1:0]            mode;
    logic [2:0]            ratio_log2;
    logic                  flush;
    logic                  clr_ovr;
    logic                  in_valid;
    logic [NC*DW-1:0]      in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [NC*OW-1:0]      out_data;
    logic                  overrun;

    int checks = 0;
    int errors = 0;

    stream_decimator #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_LOG2(ML)) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .mode       (mode),
        .ratio_log2 (ratio_log2),
        .flush      (flush),
        .clr_ovr    (clr_ovr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [31:0] och(input int c);
        logic signed [OW-1:0] v;
        v = out_data[c*OW +: OW];
        return 32'(v);
    endfunction

    task automatic drive(input int a, input int b);
        in_valid = 1'b1;
        in_data  = {DW'(b), DW'(a)};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        rst_in = 1'b0; mode = 2'b00; ratio_log2 = 3'd0; flush = 1'b0; clr_ovr = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data0", och(0), 32'd0);
        chk("rst_out_data1", och(1), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_in = 1'b1;
        tick();

        // Bypass ignores ratio_log2; one output per input, 1 clk later.
        mode = 2'b00; ratio_log2 = 3'd2;
        for (int i = 0; i < 10; i++) begin
            drive(i, -i);
            chk("byp_valid", 32'(out_valid), 32'd1);
            chk("byp_ch0", och(0), 32'(i));
            chk("byp_ch1", och(1), 32'(-i));
        end
        idle();
        chk("byp_drain", 32'(out_valid), 32'd0);

        // Keep-first, N=4.
        mode = 2'b01; ratio_log2 = 3'd2;
        for (int i = 0; i < 8; i++) begin
            drive(i + 1, 100 + i);
            chk("kf_valid", 32'(out_valid), (i % 4 == 3) ? 32'd1 : 32'd0);
            if (i == 3) begin
                chk("kf_ch0_a", och(0), 32'd1);
                chk("kf_ch1_a", och(1), 32'd100);
            end
            if (i == 7) begin
                chk("kf_ch0_b", och(0), 32'd5);
                chk("kf_ch1_b", och(1), 32'd104);
            end
        end
        idle();

        // Average, N=4: floor of -5/4 is -2.
        mode = 2'b10; ratio_log2 = 3'd2;
        drive(-3, 8191); drive(-2, 8191); drive(-1, 8191);
        chk("avg_not_yet", 32'(out_valid), 32'd0);
        drive(1, 8191);
        chk("avg_valid", 32'(out_valid), 32'd1);
        chk("avg_ch0", och(0), -32'sd2);
        chk("avg_ch1", och(1), 32'd8191);
        idle();

        // Sum, N=16, extremes without wrap.
        mode = 2'b11; ratio_log2 = 3'd4;
        for (int i = 0; i < 16; i++) drive(-8192, 8191);
        chk("sum_valid", 32'(out_valid), 32'd1);
        chk("sum_ch0", och(0), -32'sd131072);
        chk("sum_ch1", och(1), 32'd131056);
        idle();

        // ratio_log2=7 clamps to 4 (N=16).
        ratio_log2 = 3'd7;
        for (int i = 0; i < 15; i++) drive(1, 2);
        chk("clamp_not_yet", 32'(out_valid), 32'd0);
        drive(1, 2);
        chk("clamp_valid", 32'(out_valid), 32'd1);
        chk("clamp_ch0", och(0), 32'd16);
        chk("clamp_ch1", och(1), 32'd32);
        idle();

        // Backpressure and sticky overrun.
        mode = 2'b00; out_ready = 1'b0;
        drive(55, 0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_ovr_pre", 32'(overrun), 32'd0);
        drive(66, 0);
        chk("bp_ovr_set", 32'(overrun), 32'd1);
        chk("bp_hold1", och(0), 32'd55);
        drive(77, 0);
        chk("bp_hold2", och(0), 32'd55);
        clr_ovr = 1'b1;
        tick();
        chk("bp_ovr_clr", 32'(overrun), 32'd0);
        in_valid = 1'b1;
        tick();
        chk("bp_set_wins", 32'(overrun), 32'd1);
        in_valid = 1'b0;
        tick();
        clr_ovr = 1'b0;
        chk("bp_ovr_clr2", 32'(overrun), 32'd0);
        chk("bp_hold3", och(0), 32'd55);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_released", 32'(out_valid), 32'd0);
        drive(88, 0);
        chk("bp_next", och(0), 32'd88);
        idle();

        // Config change mid-block: current block stays N=4, next ones N=2.
        mode = 2'b11; ratio_log2 = 3'd2;
        drive(1, 0); drive(2, 0);
        ratio_log2 = 3'd1;
        drive(3, 0);
        chk("cfg_n4_hold", 32'(out_valid), 32'd0);
        drive(4, 0);
        chk("cfg_n4_valid", 32'(out_valid), 32'd1);
        chk("cfg_n4_sum", och(0), 32'd10);
        drive(5, 0);
        chk("cfg_n2_hold", 32'(out_valid), 32'd0);
        drive(6, 0);
        chk("cfg_n2_sum", och(0), 32'd11);
        idle();

        // Flush after 3 of 4 samples; the flush-cycle sample is discarded.
        ratio_log2 = 3'd2;
        drive(10, 0); drive(20, 0); drive(30, 0);
        flush = 1'b1;
        drive(1000, 0);
        flush = 1'b0;
        chk("fl_no_out", 32'(out_valid), 32'd0);
        drive(1, 0); drive(2, 0); drive(3, 0);
        chk("fl_not_yet", 32'(out_valid), 32'd0);
        drive(4, 0);
        chk("fl_clean_sum", och(0), 32'd10);
        out_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_keep_valid", 32'(out_valid), 32'd1);
        chk("fl_keep_data", och(0), 32'd10);
        idle();

        // Reset discards a held word and a partial block.
        out_ready = 1'b0;
        drive(1, 3); drive(2, 3); drive(3, 3); drive(4, 3);
        chk("rs_held", 32'(out_valid), 32'd1);
        rst_in = 1'b0;
        tick();
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_ch0", och(0), 32'd0);
        chk("rs_ch1", och(1), 32'd0);
        rst_in = 1'b1; out_ready = 1'b1;
        drive(1, 0); drive(2, 0);
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        drive(5, 0); drive(6, 0); drive(7, 0);
        chk("rs_partial_gone", 32'(out_valid), 32'd0);
        drive(8, 0);
        chk("rs_fresh_sum", och(0), 32'd26);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
